// File: rtl/lbs_master.sv
// Local-bus initiator: turns valid/ready requests into asynchronous host-style
// cycles (setup / strobe / hold / turnaround), all bus outputs registered.
module lbs_master #(
  parameter int SETUP_CYC  = 3,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int TURN_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [11:0] lbs_addr,
  inout  wire  [15:0] lbs_dio,
  output logic        lbs_cs_n,
  output logic        lbs_rw_n,
  output logic        lbs_oe_n
);

  if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_bad_setup
    $error("lbs_master: SETUP_CYC must be 1..255");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 255) begin : g_bad_strobe
    $error("lbs_master: STROBE_CYC must be 1..255");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
    $error("lbs_master: HOLD_CYC must be 1..255");
  end
  if (TURN_CYC < 1 || TURN_CYC > 255) begin : g_bad_turn
    $error("lbs_master: TURN_CYC must be 1..255");
  end

  localparam logic [7:0] S_M1 = 8'(SETUP_CYC - 1);
  localparam logic [7:0] T_M1 = 8'(STROBE_CYC - 1);
  localparam logic [7:0] H_M1 = 8'(HOLD_CYC - 1);
  localparam logic [7:0] U_M1 = 8'(TURN_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        cs_n_q, cs_n_d, rw_n_q, rw_n_d, oe_n_q, oe_n_d;
  logic        dio_oe_q, dio_oe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        last_cyc, accept, busy_d, strobe_end;

  wire unused_dio_hi = ^lbs_dio[15:8];

  assign last_cyc   = (cnt_q == 8'd0);
  assign accept     = (state_q == IDLE) && req_valid;
  assign strobe_end = (state_q == STROBE) && last_cyc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter holds phase length-1 on entry; phase ends when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = last_cyc ? 8'd0 : cnt_q - 8'd1;
    case (state_q)
      IDLE:    begin
        cnt_d = 8'd0;
        if (req_valid) begin state_d = SETUP; cnt_d = S_M1; end
      end
      SETUP:   if (last_cyc) begin state_d = STROBE; cnt_d = T_M1; end
      STROBE:  if (last_cyc) begin state_d = HOLD;   cnt_d = H_M1; end
      HOLD:    if (last_cyc) begin state_d = TURN;   cnt_d = U_M1; end
      TURN:    if (last_cyc) begin state_d = IDLE;   cnt_d = 8'd0; end
      default: begin state_d = IDLE; cnt_d = 8'd0; end
    endcase
  end

  // Bus outputs are computed from the next state so they switch on the same
  // edge as the state register, without combinational glitches.
  always_comb begin
    wr_d        = accept ? req_wr    : wr_q;
    addr_d      = accept ? req_addr  : addr_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    busy_d      = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d      = !busy_d;
    rw_n_d      = !((state_d == STROBE) && wr_d);
    oe_n_d      = !((state_d == STROBE) && !wr_d);
    dio_oe_d    = busy_d && wr_d;
    rsp_valid_d = strobe_end;
    rdata_d     = (strobe_end && !wr_q) ? lbs_dio[7:0] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q        <= 1'b0;
      addr_q      <= 12'h000;
      wdata_q     <= 8'h00;
      cs_n_q      <= 1'b1;
      rw_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dio_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_n_q      <= cs_n_d;
      rw_n_q      <= rw_n_d;
      oe_n_q      <= oe_n_d;
      dio_oe_q    <= dio_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign lbs_addr  = addr_q;
  assign lbs_cs_n  = cs_n_q;
  assign lbs_rw_n  = rw_n_q;
  assign lbs_oe_n  = oe_n_q;
  assign lbs_dio   = dio_oe_q ? {8'h00, wdata_q} : 16'hzzzz;

endmodule

// File: doc/lbs_master.md
Name: lbs_master

Overview:
- Local-bus initiator: generates asynchronous host-style cycles on lbs_addr/lbs_dio/lbs_cs_n/lbs_rw_n/lbs_oe_n from a simple valid/ready request port.
- Used by the board-level bench to exercise the FPGA's local-bus slave decode (CIB/UART/CAN address map).
- Also used on the control board to drive external byte-wide peripherals over the same bus format.
- Timing phases (setup, strobe, hold, turnaround) are parameterised in clk cycles.

Parameters:
- SETUP_CYC, 3, cycles cs_n low with address/data stable before strobe; legal 1..255, >=3 for the FPGA slave.
- STROBE_CYC, 4, cycles rw_n (write) or oe_n (read) held low; legal 1..255, >=4 for the FPGA slave.
- HOLD_CYC, 2, cycles cs_n/address/data held after strobe release; legal 1..255.
- TURN_CYC, 2, cycles cs_n high with lbs_dio released before next access; legal 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  master idle, request accepted on req_valid&&req_ready at clk edge.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  12  bus address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle completion pulse, reads and writes.
- rsp_rdata  out  8  captured read byte, held until next read completes.
- lbs_addr  out  12  bus address.
- lbs_dio  inout  16  data bus; driven {8'h00,wdata} on writes, Z otherwise.
- lbs_cs_n  out  1  chip select, active low.
- lbs_rw_n  out  1  write strobe, active low.
- lbs_oe_n  out  1  read strobe, active low.

Behaviour:
- Reset:
  - Every registered output goes idle on the first clk edge with rst_n=0, including reset asserted mid-access: lbs_cs_n=1, lbs_rw_n=1, lbs_oe_n=1, lbs_addr=0, lbs_dio=Z, rsp_valid=0, rsp_rdata=0, state IDLE.
  - req_ready=1 in IDLE.
- FSM states IDLE -> SETUP -> STROBE -> HOLD -> TURN -> IDLE. One 8-bit down-counter is loaded with phase length-1 on each phase entry.
- IDLE:
  - req_ready=1 only here.
  - On accept at edge k, latch wr/addr/wdata. Enter SETUP for cycle k+1.
- SETUP (cycles k+1..k+S):
  - lbs_addr=addr, lbs_cs_n=0, both strobes high.
  - Write: lbs_dio driven from k+1.
- STROBE (next T cycles): write drives lbs_rw_n=0; read drives lbs_oe_n=0. lbs_rw_n and lbs_oe_n are never both low.
- Read capture: lbs_dio[7:0] is registered into rsp_rdata on the clk edge that ends the last STROBE cycle.
- HOLD (next H cycles):
  - Strobes high; cs_n, addr and write data held.
  - rsp_valid=1 in the first HOLD cycle only. For reads, rsp_rdata is valid in that cycle.
- TURN (next U cycles):
  - lbs_cs_n=1, lbs_dio=Z.
  - lbs_addr holds its last value.
- Latency: req_ready is high again in cycle k+S+T+H+U+1, which is k+12 with defaults. With req_valid held high, back-to-back accesses are accepted at that cycle.
- Write data: lbs_dio is driven only from the first SETUP cycle to the last HOLD cycle of a write. It is never driven during reads or idle.
- Glitch-free outputs: all bus outputs and the lbs_dio output-enable are registered.
- No abort: requests presented while busy are ignored (req_ready=0). There is no timeout.
- Illegal parameters (0 or >255): an elaboration-time error is raised.

Test Plan:
- Write, defaults: req wr=1 addr=12'h8A5 wdata=8'h3C accepted at edge k.
  - lbs_cs_n low k+1..k+9.
  - lbs_rw_n low exactly k+4..k+7; lbs_oe_n stays 1.
  - lbs_dio=16'h003C k+1..k+9, Z at k+10.
  - rsp_valid single pulse at k+8; req_ready=1 at k+12.
- Read: addr=12'h105, bench slave drives lbs_dio=16'h00A7 while oe_n low.
  - lbs_oe_n low k+4..k+7; master never drives lbs_dio.
  - rsp_valid at k+8 with rsp_rdata=8'hA7.
- Back-to-back: req_valid held high with write 12'h001/8'h11 then read 12'hF00. Second access is accepted at k+12; its strobe is lbs_oe_n low k+16..k+19.
- Parameter sweep SETUP=1 STROBE=1 HOLD=1 TURN=1: write has rw_n low a single cycle k+2, rsp_valid at k+3, ready at k+5.
- Reset mid-strobe: rst_n=0 at edge k+5 of a write.
  - Next cycle all outputs are idle: cs_n=1, rw_n=1, dio=Z, addr=0, rsp_valid=0.
  - After release, a new read completes normally.
- Ready protocol: toggle req_valid during HOLD/TURN. No second access starts and no extra rsp_valid appears.
- Whole test: rw_n and oe_n are never low simultaneously, and no strobe is ever low with cs_n high (assertions).
